// File: rtl/ili934x_bus_decoder_if.sv
// ILI934x 8080-8 write bus bundle.
// The master modport is the side that drives the panel bus (LCD write engine
// or a testbench). The slave modport is the panel-side receiver.
//   lcd_cs_n : chip select, active low
//   lcd_rd_n : read strobe (the decoder never answers reads)
//   lcd_dc   : 0 = command byte, 1 = data/parameter byte
//   lcd_wr_n : write strobe, byte taken on its rising edge
//   lcd_d    : 8-bit bus data
interface ili934x_bus_decoder_if;
  logic       lcd_cs_n;
  logic       lcd_rd_n;
  logic       lcd_dc;
  logic       lcd_wr_n;
  logic [7:0] lcd_d;

  modport master (
    output lcd_cs_n,
    output lcd_rd_n,
    output lcd_dc,
    output lcd_wr_n,
    output lcd_d
  );

  modport slave (
    input lcd_cs_n,
    input lcd_rd_n,
    input lcd_dc,
    input lcd_wr_n,
    input lcd_d
  );
endinterface

// File: rtl/ili934x_bus_decoder.sv
// Panel-side responder for the ILI934x 8080-8 write bus.
// Samples the asynchronous write bus, decodes the command/parameter stream,
// tracks the CASET/PASET window and emits addressed RGB565 pixel writes.
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   bus (slave)       : cs_n / rd_n / dc / wr_n / d from the bus master
//   cmd_valid/cmd_code: one-cycle pulse and last command byte
//   pix_valid/pix_x/pix_y/pix_data : one pulse per in-range RGB565 pixel
//   disp_on, sleep_out, madctl, colmod : panel status registers
//   err_oob           : sticky out-of-range / inverted-window flag
module ili934x_bus_decoder #(
  parameter int X_RES = 240,
  parameter int Y_RES = 320
) (
  input  logic                        clk,
  input  logic                        rst,
  ili934x_bus_decoder_if.slave        bus,
  output logic                        cmd_valid,
  output logic [7:0]                  cmd_code,
  output logic                        pix_valid,
  output logic [15:0]                 pix_x,
  output logic [15:0]                 pix_y,
  output logic [15:0]                 pix_data,
  output logic                        disp_on,
  output logic                        sleep_out,
  output logic [7:0]                  madctl,
  output logic [7:0]                  colmod,
  output logic                        err_oob
);

  localparam logic [15:0] X_LIM = 16'(X_RES);
  localparam logic [15:0] Y_LIM = 16'(Y_RES);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PARAM  = 3'd1;
  localparam logic [2:0] ST_IGNORE = 3'd2;
  localparam logic [2:0] ST_RAM_HI = 3'd3;
  localparam logic [2:0] ST_RAM_LO = 3'd4;

  // Synchronizer word layout: {cs_n, dc, wr_n, d[7:0]}; idle = cs_n/wr_n high.
  localparam logic [10:0] BUS_IDLE = 11'h500;

  logic [10:0] sync1, sync2;
  logic        wr_prev;
  logic        ev, ev_dc, is_cmd, is_data, soft_rst, win_inverted;
  logic [7:0]  ev_d;

  logic [2:0]  state;
  logic [7:0]  param_cmd;
  logic [1:0]  param_cnt;
  logic [23:0] param_buf;
  logic [15:0] sc, ec, sp, ep, x, y;
  logic [7:0]  hi_byte;
  logic        win_bad;

  // The read strobe is part of the bus but reads get no response.
  logic unused_rd;
  assign unused_rd = bus.lcd_rd_n;

  // Two-flop synchronizer on every bus input plus one more stage of wr_n so
  // a rising strobe edge can be seen. Reset to the idle bus so that an edge
  // straddling reset cannot produce a phantom event.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= BUS_IDLE;
      sync2   <= BUS_IDLE;
      wr_prev <= 1'b1;
    end else begin
      sync1   <= {bus.lcd_cs_n, bus.lcd_dc, bus.lcd_wr_n, bus.lcd_d};
      sync2   <= sync1;
      wr_prev <= sync2[8];
    end
  end

  assign ev           = sync2[8] & ~wr_prev & ~sync2[10];
  assign ev_dc        = sync2[9];
  assign ev_d         = sync2[7:0];
  assign is_cmd       = ev & ~ev_dc;
  assign is_data      = ev & ev_dc;
  assign soft_rst     = rst | (is_cmd && ev_d == 8'h01);
  assign win_inverted = (sc > ec) || (sp > ep);

  // Command reporting survives SWRESET, so it lives apart from the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_code  <= 8'h00;
    end else begin
      cmd_valid <= is_cmd;
      if (is_cmd) cmd_code <= ev_d;
    end
  end

  // Decode state, window registers, address counters and panel status.
  // A command always wins over whatever byte sequence was in progress.
  always_ff @(posedge clk) begin
    pix_valid <= 1'b0;
    if (soft_rst) begin
      state     <= ST_IDLE;
      param_cmd <= 8'h00;
      param_cnt <= 2'd0;
      param_buf <= 24'h0;
      sc        <= 16'h0;
      ec        <= 16'(X_RES - 1);
      sp        <= 16'h0;
      ep        <= 16'(Y_RES - 1);
      x         <= 16'h0;
      y         <= 16'h0;
      hi_byte   <= 8'h00;
      win_bad   <= 1'b0;
      pix_x     <= 16'h0;
      pix_y     <= 16'h0;
      pix_data  <= 16'h0;
      disp_on   <= 1'b0;
      sleep_out <= 1'b0;
      madctl    <= 8'h00;
      colmod    <= 8'h66;
      err_oob   <= 1'b0;
    end else if (is_cmd) begin
      case (ev_d)
        8'h2A, 8'h2B, 8'h36, 8'h3A: begin
          state     <= ST_PARAM;
          param_cmd <= ev_d;
          param_cnt <= 2'd0;
        end
        8'h2C, 8'h3C: begin
          if (ev_d == 8'h2C) begin
            x <= sc;
            y <= sp;
          end
          win_bad <= win_inverted;
          if (win_inverted) err_oob <= 1'b1;
          state <= ST_RAM_HI;
        end
        8'h11: begin sleep_out <= 1'b1; state <= ST_IDLE; end
        8'h10: begin sleep_out <= 1'b0; state <= ST_IDLE; end
        8'h29: begin disp_on   <= 1'b1; state <= ST_IDLE; end
        8'h28: begin disp_on   <= 1'b0; state <= ST_IDLE; end
        default: state <= ST_IGNORE;
      endcase
    end else if (is_data) begin
      case (state)
        ST_PARAM: begin
          if (param_cmd == 8'h36) begin
            madctl <= ev_d;
            state  <= ST_IDLE;
          end else if (param_cmd == 8'h3A) begin
            colmod <= ev_d;
            state  <= ST_IDLE;
          end else if (param_cnt == 2'd3) begin
            // Buffer now holds {start_hi, start_lo, end_hi}.
            if (param_cmd == 8'h2A) begin
              sc <= param_buf[23:8];
              ec <= {param_buf[7:0], ev_d};
            end else begin
              sp <= param_buf[23:8];
              ep <= {param_buf[7:0], ev_d};
            end
            state <= ST_IDLE;
          end else begin
            param_buf <= {param_buf[15:0], ev_d};
            param_cnt <= param_cnt + 2'd1;
          end
        end
        ST_RAM_HI: begin
          hi_byte <= ev_d;
          state   <= ST_RAM_LO;
        end
        ST_RAM_LO: begin
          if (x < X_LIM && y < Y_LIM) begin
            pix_valid <= 1'b1;
            pix_x     <= x;
            pix_y     <= y;
            pix_data  <= {hi_byte, ev_d};
          end else begin
            err_oob <= 1'b1;
          end
          // An inverted window has no meaningful wrap point, so the
          // address just counts through the 16-bit space.
          if (win_bad) begin
            x <= x + 16'd1;
            if (x == 16'hFFFF) y <= y + 16'd1;
          end else if (x == ec) begin
            x <= sc;
            y <= (y == ep) ? sp : y + 16'd1;
          end else begin
            x <= x + 16'd1;
          end
          state <= ST_RAM_HI;
        end
        default: state <= ST_IGNORE;
      endcase
    end
  end

endmodule
